// File: rtl/csr_trap_unit.sv
// Trap/xRET sequencer with the M/S trap CSRs (epc, cause, tval, mstatus).
// Build option: define TRAP_VECTORED_EN to dispatch interrupts through vectored tvec (mode 1).
module csr_trap_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] mip_i,
   input  logic [XLEN-1:0] mie_i,
   input  logic [XLEN-1:0] mideleg_i,
   input  logic [XLEN-1:0] medeleg_i,
   input  logic            exc_valid_i,
   input  logic [5:0]      exc_cause_i,
   input  logic [XLEN-1:0] exc_pc_i,
   input  logic [XLEN-1:0] exc_tval_i,
   input  logic            ret_valid_i,
   input  logic            ret_is_mret_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] stvec_i,
   input  logic            drained_i,
   input  logic            mstatus_we_i,
   input  logic            sstatus_we_i,
   input  logic [XLEN-1:0] status_wdata_i,
   output logic            busy_o,
   output logic [1:0]      priv_o,
   output logic [XLEN-1:0] mstatus_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] sepc_o,
   output logic [XLEN-1:0] mcause_o,
   output logic [XLEN-1:0] scause_o,
   output logic [XLEN-1:0] mtval_o,
   output logic [XLEN-1:0] stval_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o
);
   typedef enum logic [1:0] {PRIV_U = 2'b00, PRIV_S = 2'b01, PRIV_M = 2'b11} privilege_t;
   typedef enum logic [1:0] {IDLE, DRAIN, UPDATE, REDIRECT} state_t;

   localparam int SIE = 1, MIE = 3, SPIE = 5, MPIE = 7, SPP = 8, MPP_LO = 11, MPP_HI = 12;
   localparam logic [XLEN-1:0] MSTATUS_WRITE_MASK = XLEN'(64'h0000_0000_007E_79AA);
   localparam logic [XLEN-1:0] SSTATUS_WRITE_MASK = XLEN'(64'h0000_0000_000C_6122);
   localparam logic [XLEN-1:0] XLEN_64_FIELDS     = XLEN'(64'h0000_000A_0000_0000);
   localparam int IRQ_ORDER [6] = '{11, 3, 7, 9, 1, 5};

   state_t          state, next_state;
   privilege_t      priv;
   logic [XLEN-1:0] status;  // holds only the software-writable mstatus fields
   logic [XLEN-1:0] mepc, sepc, mcause, scause, mtval, stval, redirect_pc;
   logic            req_ret, req_mret, req_int, req_to_s;
   logic [5:0]      req_cause;
   logic [XLEN-1:0] req_pc, req_tval;

   logic [XLEN-1:0] pend, eligible, m_wdata;
   logic            m_ok, s_ok, int_hit, accept;
   logic [5:0]      int_cause;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      int_hit   = 1'b0;
      int_cause = '0;
      pend      = mip_i & mie_i;
      m_ok      = (priv != PRIV_M) || status[MIE];
      s_ok      = (priv == PRIV_U) || ((priv == PRIV_S) && status[SIE]);
      eligible  = (pend & ~mideleg_i & {XLEN{m_ok}}) | (pend & mideleg_i & {XLEN{s_ok}});
      // Scan lowest priority first so the highest-priority eligible source wins.
      for (int i = 5; i >= 0; i--) begin
         if (eligible[IRQ_ORDER[i]]) begin
            int_hit   = 1'b1;
            int_cause = 6'(IRQ_ORDER[i]);
         end
      end
      accept  = (state == IDLE) && (exc_valid_i || ret_valid_i || int_hit);
      m_wdata = status_wdata_i & MSTATUS_WRITE_MASK;
      if (m_wdata[MPP_HI:MPP_LO] == 2'b10) m_wdata[MPP_HI:MPP_LO] = 2'b00;
   end

   logic [XLEN-1:0] tvec, trap_pc, trap_cause, trap_tval;
   always_comb begin
      tvec       = req_to_s ? stvec_i : mtvec_i;
      trap_pc    = {tvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if (req_int && (tvec[1:0] == 2'b01))
         trap_pc = trap_pc + {{(XLEN-8){1'b0}}, req_cause, 2'b00};
`endif
      trap_cause = {req_int, {(XLEN-7){1'b0}}, req_cause};
      trap_tval  = req_int ? '0 : req_tval;
   end

   logic unused_bits;
   assign unused_bits = ^{eligible, tvec[1:0]};

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:     if (accept) next_state = DRAIN;
         DRAIN:    if (drained_i) next_state = UPDATE;
         UPDATE:   next_state = REDIRECT;
         REDIRECT: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_o              = (state != IDLE);
      redirect_valid_o    = (state == REDIRECT);
      redirect_pc_o       = (state == REDIRECT) ? redirect_pc : '0;
      priv_o              = priv;
      mstatus_o           = status | XLEN_64_FIELDS;
      mstatus_o[XLEN-1]   = (status[14:13] == 2'b11);
      mepc_o   = mepc;   sepc_o   = sepc;
      mcause_o = mcause; scause_o = scause;
      mtval_o  = mtval;  stval_o  = stval;
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state       <= IDLE;
         priv        <= PRIV_M;
         status      <= '0;
         mepc        <= '0;  sepc   <= '0;
         mcause      <= '0;  scause <= '0;
         mtval       <= '0;  stval  <= '0;
         redirect_pc <= '0;
         req_ret     <= 1'b0; req_mret <= 1'b0; req_int <= 1'b0; req_to_s <= 1'b0;
         req_cause   <= '0;
         req_pc      <= '0;
         req_tval    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            req_ret   <= !exc_valid_i && ret_valid_i;
            req_mret  <= ret_is_mret_i;
            req_int   <= !exc_valid_i && !ret_valid_i;
            req_cause <= exc_valid_i ? exc_cause_i : int_cause;
            req_to_s  <= exc_valid_i ? (medeleg_i[exc_cause_i] && (priv != PRIV_M))
                                     : mideleg_i[int_cause];
            req_pc    <= exc_pc_i;
            req_tval  <= exc_tval_i;
         end
         // Software status writes colliding with UPDATE are dropped.
         if (state == UPDATE) begin
            if (req_ret && req_mret) begin
               priv                   <= privilege_t'(status[MPP_HI:MPP_LO]);
               status[MIE]            <= status[MPIE];
               status[MPIE]           <= 1'b1;
               status[MPP_HI:MPP_LO]  <= 2'b00;
               redirect_pc            <= mepc;
            end else if (req_ret) begin
               priv                   <= privilege_t'({1'b0, status[SPP]});
               status[SIE]            <= status[SPIE];
               status[SPIE]           <= 1'b1;
               status[SPP]            <= 1'b0;
               redirect_pc            <= sepc;
            end else if (req_to_s) begin
               sepc                   <= req_pc;
               scause                 <= trap_cause;
               stval                  <= trap_tval;
               status[SPIE]           <= status[SIE];
               status[SIE]            <= 1'b0;
               status[SPP]            <= priv[0];
               priv                   <= PRIV_S;
               redirect_pc            <= trap_pc;
            end else begin
               mepc                   <= req_pc;
               mcause                 <= trap_cause;
               mtval                  <= trap_tval;
               status[MPIE]           <= status[MIE];
               status[MIE]            <= 1'b0;
               status[MPP_HI:MPP_LO]  <= priv;
               priv                   <= PRIV_M;
               redirect_pc            <= trap_pc;
            end
         end else if (mstatus_we_i) begin
            status <= m_wdata;
         end else if (sstatus_we_i) begin
            status <= (status & ~SSTATUS_WRITE_MASK) | (status_wdata_i & SSTATUS_WRITE_MASK);
         end
      end
   end
endmodule

// File: tb/tb_csr_trap_unit.sv
// Randomized scoreboard bench for csr_trap_unit against a field-level privilege/trap model.
module tb_csr_trap_unit;
   logic        clk, reset;
   logic [63:0] mip_i, mie_i, mideleg_i, medeleg_i, exc_pc_i, exc_tval_i, mtvec_i, stvec_i;
   logic [63:0] status_wdata_i;
   logic [5:0]  exc_cause_i;
   logic        exc_valid_i, ret_valid_i, ret_is_mret_i, drained_i, mstatus_we_i, sstatus_we_i;
   logic        busy_o, redirect_valid_o;
   logic [1:0]  priv_o;
   logic [63:0] mstatus_o, mepc_o, sepc_o, mcause_o, scause_o, mtval_o, stval_o, redirect_pc_o;

   csr_trap_unit #(.XLEN(64)) dut (
      .clk(clk), .reset(reset),
      .mip_i(mip_i), .mie_i(mie_i), .mideleg_i(mideleg_i), .medeleg_i(medeleg_i),
      .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
      .exc_tval_i(exc_tval_i), .ret_valid_i(ret_valid_i), .ret_is_mret_i(ret_is_mret_i),
      .mtvec_i(mtvec_i), .stvec_i(stvec_i), .drained_i(drained_i),
      .mstatus_we_i(mstatus_we_i), .sstatus_we_i(sstatus_we_i), .status_wdata_i(status_wdata_i),
      .busy_o(busy_o), .priv_o(priv_o), .mstatus_o(mstatus_o), .mepc_o(mepc_o), .sepc_o(sepc_o),
      .mcause_o(mcause_o), .scause_o(scause_o), .mtval_o(mtval_o), .stval_o(stval_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  priv;
      logic        sie, mie, spie, mpie, spp, mprv, sum, mxr, tvm, tw, tsr;
      logic [1:0]  mpp, fs;
      logic [63:0] mepc, sepc, mcause, scause, mtval, stval;
   } model_t;
   typedef struct {
      logic [63:0] rpc, mstatus, mepc, sepc, mcause, scause, mtval, stval;
      logic [1:0]  priv;
   } exp_t;

   model_t md;
   exp_t   exp_q[$];
   int     total = 0;
   int     bad = 0;
   localparam int IRQ_PRIO [6] = '{11, 3, 7, 9, 1, 5};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h @%0t", name, act, want, $time);
      end
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] status_of(input model_t m);
      logic [63:0] s;
      s = 64'h0;
      s[1] = m.sie;  s[3] = m.mie;  s[5] = m.spie; s[7] = m.mpie; s[8] = m.spp;
      s[12:11] = m.mpp; s[14:13] = m.fs;
      s[17] = m.mprv; s[18] = m.sum; s[19] = m.mxr; s[20] = m.tvm; s[21] = m.tw; s[22] = m.tsr;
      s[33:32] = 2'b10; s[35:34] = 2'b10;
      s[63] = (m.fs == 2'b11);
      return s;
   endfunction

   task automatic model_reset();
      md.priv = 2'b11;
      md.sie = 0; md.mie = 0; md.spie = 0; md.mpie = 0; md.spp = 0; md.mprv = 0;
      md.sum = 0; md.mxr = 0; md.tvm = 0; md.tw = 0; md.tsr = 0; md.mpp = 0; md.fs = 0;
      md.mepc = 0; md.sepc = 0; md.mcause = 0; md.scause = 0; md.mtval = 0; md.stval = 0;
   endtask

   // Decide the outcome of the request currently driven and push the expected redirect.
   task automatic model_request(output bit taken);
      exp_t        e;
      bit          is_int, is_ret, to_s, ok;
      int          cause;
      logic [63:0] tvec, ecause, etval;
      taken = 0; is_int = 0; is_ret = 0; to_s = 0; cause = 0; e.rpc = 0;
      if (exc_valid_i) begin
         taken = 1; cause = int'(exc_cause_i);
         to_s = medeleg_i[exc_cause_i] && (md.priv != 2'b11);
      end else if (ret_valid_i) begin
         taken = 1; is_ret = 1;
         if (ret_is_mret_i) begin
            e.rpc = md.mepc; md.priv = md.mpp; md.mie = md.mpie; md.mpie = 1; md.mpp = 2'b00;
         end else begin
            e.rpc = md.sepc; md.priv = {1'b0, md.spp}; md.sie = md.spie; md.spie = 1; md.spp = 0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (!taken && mip_i[IRQ_PRIO[i]] && mie_i[IRQ_PRIO[i]]) begin
               if (mideleg_i[IRQ_PRIO[i]]) ok = (md.priv == 2'b00) || (md.priv == 2'b01 && md.sie);
               else ok = (md.priv != 2'b11) || md.mie;
               if (ok) begin
                  taken = 1; is_int = 1; cause = IRQ_PRIO[i]; to_s = mideleg_i[IRQ_PRIO[i]];
               end
            end
         end
      end
      if (!taken) return;
      if (!is_ret) begin
         ecause = is_int ? (64'h1 << 63) + 64'(cause) : 64'(cause);
         etval  = is_int ? 64'h0 : exc_tval_i;
         if (to_s) begin
            md.sepc = exc_pc_i; md.scause = ecause; md.stval = etval;
            md.spie = md.sie; md.sie = 0; md.spp = md.priv[0]; md.priv = 2'b01; tvec = stvec_i;
         end else begin
            md.mepc = exc_pc_i; md.mcause = ecause; md.mtval = etval;
            md.mpie = md.mie; md.mie = 0; md.mpp = md.priv; md.priv = 2'b11; tvec = mtvec_i;
         end
         e.rpc = tvec & ~64'h3;
`ifdef TRAP_VECTORED_EN
         if (is_int && tvec[1:0] == 2'b01) e.rpc = e.rpc + 64'(4 * cause);
`endif
      end
      e.priv = md.priv; e.mstatus = status_of(md);
      e.mepc = md.mepc; e.sepc = md.sepc; e.mcause = md.mcause; e.scause = md.scause;
      e.mtval = md.mtval; e.stval = md.stval;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every redirect against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (redirect_valid_o) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_redirect: got pc=%h want=no redirect", redirect_pc_o);
         end else begin
            e = exp_q.pop_front();
            check("redirect_pc", redirect_pc_o, e.rpc);
            check("priv", 64'(priv_o), 64'(e.priv));
            check("mstatus", mstatus_o, e.mstatus);
            check("mepc", mepc_o, e.mepc);     check("sepc", sepc_o, e.sepc);
            check("mcause", mcause_o, e.mcause); check("scause", scause_o, e.scause);
            check("mtval", mtval_o, e.mtval);   check("stval", stval_o, e.stval);
         end
      end else begin
         check("redirect_pc_idle_zero", redirect_pc_o, 64'h0);
      end
   end

   task automatic issue(input bit ev, input logic [5:0] ec, input logic [63:0] pc, tval,
                        input bit rv, rm, input logic [63:0] mip, mie, mid, med);
      bit taken;
      exc_valid_i = ev; exc_cause_i = ec; exc_pc_i = pc; exc_tval_i = tval;
      ret_valid_i = rv; ret_is_mret_i = rm;
      mip_i = mip; mie_i = mie; mideleg_i = mid; medeleg_i = med;
      model_request(taken);
      @(posedge clk); #1;
      exc_valid_i = 0; ret_valid_i = 0; mip_i = 0;
      check("busy_after_request", 64'(busy_o), 64'(taken));
   endtask

   task automatic wait_idle(input bit rand_drain);
      int n;
      n = 0;
      while (busy_o && n < 100) begin
         drained_i = (rand_drain && n < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      drained_i = 1;
      check("idle_within_bound", 64'(busy_o), 64'h0);
   endtask

   task automatic sw_write(input bit is_m, input logic [63:0] w);
      mip_i = 0; mstatus_we_i = is_m; sstatus_we_i = !is_m; status_wdata_i = w;
      @(posedge clk); #1;
      mstatus_we_i = 0; sstatus_we_i = 0;
      if (is_m) begin
         md.sie = w[1]; md.mie = w[3]; md.spie = w[5]; md.mpie = w[7]; md.spp = w[8];
         md.mpp = (w[12:11] == 2'b10) ? 2'b00 : w[12:11];
         md.fs = w[14:13]; md.mprv = w[17]; md.sum = w[18]; md.mxr = w[19];
         md.tvm = w[20]; md.tw = w[21]; md.tsr = w[22];
      end else begin
         md.sie = w[1]; md.spie = w[5]; md.spp = w[8]; md.fs = w[14:13]; md.sum = w[18]; md.mxr = w[19];
      end
      check(is_m ? "mstatus_write" : "sstatus_write", mstatus_o, status_of(md));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 64'h0);
      check({tag, "_priv"}, 64'(priv_o), 64'h3);
      check({tag, "_rvalid"}, 64'(redirect_valid_o), 64'h0);
      check({tag, "_rpc"}, redirect_pc_o, 64'h0);
      check({tag, "_mstatus"}, mstatus_o, 64'h0000_000A_0000_0000);
      check({tag, "_mepc"}, mepc_o, 64'h0);     check({tag, "_sepc"}, sepc_o, 64'h0);
      check({tag, "_mcause"}, mcause_o, 64'h0); check({tag, "_scause"}, scause_o, 64'h0);
      check({tag, "_mtval"}, mtval_o, 64'h0);   check({tag, "_stval"}, stval_o, 64'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind;
      reset = 1; drained_i = 1; exc_valid_i = 0; ret_valid_i = 0; ret_is_mret_i = 0;
      exc_cause_i = 0; exc_pc_i = 0; exc_tval_i = 0; mip_i = 0; mie_i = 0;
      mideleg_i = 0; medeleg_i = 0; mtvec_i = 64'h8000_0001; stvec_i = 64'h4000;
      mstatus_we_i = 0; sstatus_we_i = 0; status_wdata_i = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 0;
      @(posedge clk); #1;

      // MEI from U, non-delegated; also checks the 3-cycle latency.
      sw_write(1, 64'h80);                                  // mpie=1, mpp=U
      issue(0, 0, 64'h0, 64'h0, 1, 1, 0, 0, 0, 0);          // MRET -> U, mie=1
      wait_idle(0);
      check("to_user", 64'(priv_o), 64'h0);
      issue(0, 0, 64'h2000, 64'h0, 0, 0, 64'h880, 64'h880, 0, 0);
      check("lat_cycle2", 64'(redirect_valid_o), 64'h0);
      @(posedge clk); #1;
      check("lat_cycle3_update", 64'(redirect_valid_o), 64'h0);
      @(posedge clk); #1;
      check("lat_redirect", 64'(redirect_valid_o), 64'h1);
      wait_idle(0);
      check("mei_mcause", mcause_o, 64'h8000_0000_0000_000B);
      check("mei_priv", 64'(priv_o), 64'h3);
      check("mei_mpp", 64'(mstatus_o[12:11]), 64'h0);

      // Delegated exception from U with a slow drain.
      issue(0, 0, 64'h0, 64'h0, 1, 1, 0, 0, 0, 0);          // back to U
      wait_idle(0);
      drained_i = 0;
      issue(1, 6'd8, 64'h1000, 64'h55, 0, 0, 0, 0, 0, 64'h100);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("drain_hold_busy", 64'(busy_o), 64'h1);
         check("drain_no_redirect", 64'(redirect_valid_o), 64'h0);
      end
      drained_i = 1;
      @(posedge clk); #1;
      check("drain_update", 64'(redirect_valid_o), 64'h0);
      @(posedge clk); #1;
      check("drain_redirect", 64'(redirect_valid_o), 64'h1);
      wait_idle(0);
      check("s_sepc", sepc_o, 64'h1000);
      check("s_scause", scause_o, 64'h8);
      check("s_spp", 64'(mstatus_o[8]), 64'h0);
      check("s_priv", 64'(priv_o), 64'h1);

      // M trap from S (mpp=S, mpie=1), then MRET back to S.
      issue(1, 6'd2, 64'h3000, 64'h77, 0, 0, 0, 0, 0, 0);
      wait_idle(0);
      issue(0, 0, 64'h0, 64'h0, 1, 1, 0, 0, 0, 0);
      wait_idle(0);
      check("mret_priv", 64'(priv_o), 64'h1);
      check("mret_mie", 64'(mstatus_o[3]), 64'h1);
      check("mret_mpp", 64'(mstatus_o[12:11]), 64'h0);

      // Exception beats a simultaneous return; sstatus write of all ones.
      issue(1, 6'd3, 64'h5000, 64'h99, 1, 1, 0, 0, 0, 0);
      wait_idle(0);
      check("exc_wins_mcause", mcause_o, 64'h3);
      check("exc_wins_priv", 64'(priv_o), 64'h3);
      sw_write(0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("uxl_kept", 64'(mstatus_o[33:32]), 64'h2);

      // Software write in the UPDATE cycle is discarded.
      issue(1, 6'd5, 64'h6000, 64'h11, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      mstatus_we_i = 1; status_wdata_i = 64'h0;
      @(posedge clk); #1;
      mstatus_we_i = 0;
      wait_idle(0);
      check("update_beats_write", mstatus_o, status_of(md));

      // Reset while waiting in DRAIN aborts the trap.
      drained_i = 0;
      issue(1, 6'd4, 64'h7000, 64'h22, 0, 0, 0, 0, 0, 0);
      #2 reset = 1;
      #1 check_reset_state("midreset");
      exp_q.delete();
      model_reset();
      @(posedge clk); #1;
      reset = 0; drained_i = 1;
      repeat (5) @(posedge clk);
      #1 check("no_resume_after_reset", 64'(busy_o), 64'h0);

      // Random mix.
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 5);
         mtvec_i = r64(); stvec_i = r64();
         drained_i = 1'($urandom_range(0, 1));
         case (kind)
            0: issue(1, 6'($urandom_range(0, 63)), r64(), r64(), 0, 0, 0, r64(), r64(), r64());
            1: issue(0, 0, r64(), r64(), 1, 1'($urandom_range(0, 1)), 0, r64(), r64(), r64());
            2: issue(0, 0, r64(), r64(), 0, 0, r64() & 64'hAAA, r64() | 64'hAAA, r64(), r64());
            3: sw_write(1, r64());
            4: sw_write(0, r64());
            default: issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), r64(), r64(),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           r64() & 64'hAAA, r64(), r64(), r64());
         endcase
         wait_idle(1);
      end

      @(posedge clk); #1;
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
